contador_checker: RTL
=====================

# contador_checker

Synthesizable self-checking monitor for the 8-bit up/down counter (`contador`). It sits beside the counter and observes the same `enable` and `modo_UpDown` controls plus the counter's `salida`. It runs a cycle-accurate reference model of the counter and flags every cycle where `salida` differs from the prediction. Counters and sticky status make it usable both in simulation and as on-chip debug logic.

## Interface
- `WIDTH`, default 8: counter data width; must match the counter being checked.
- `CW`, default 8: width of the error and compare counters.
- `STOP_ON_ERR`, default 0: 1 = halt checking after the first mismatch; 0 = resync and continue.

- `clk`  in  1  clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset. It is shared with the counter, which is also reset to 0.
- `enable`  in  1  counter enable, the same signal the counter sees.
- `modo_UpDown`  in  1  count direction: 1 = down, 0 = up.
- `salida`  in  WIDTH  observed counter output.
- `check_en`  in  1  1 = compare `salida` this cycle; 0 = model only.
- `esperado`  out  WIDTH  model value predicted for the current `salida`.
- `error`  out  1  one-cycle pulse, registered, for each detected mismatch.
- `fail`  out  1  sticky; set by the first mismatch, cleared only by `reset`.
- `err_count`  out  CW  mismatches seen; saturates at 2^CW-1.
- `cmp_count`  out  CW  comparisons performed; saturates at 2^CW-1.
- `estado`  out  2  FSM state: IDLE=0, TRACK=1, HALT=2.

## Operation
- **Reference model:** next(v) = v-1 if `modo_UpDown`=1, otherwise v+1. The result is taken modulo 2^WIDTH, so 0 minus 1 gives 255 and 255 plus 1 gives 0. The model advances only when `enable`=1.
- **Compare condition:** `cmp` = (`estado`==TRACK) & `check_en`. A mismatch (`mm`) is `cmp` & (`salida` != `esperado`).
- **Model update every edge:**
  - no mismatch: `esperado` <= next(`esperado`) when `enable`=1, otherwise it holds.
  - mismatch in TRACK with `STOP_ON_ERR`=0: the model resyncs to the observed value, `esperado` <= (`enable` ? next(`salida`) : `salida`).
  - HALT: `esperado` freezes.
- **FSM transitions:**
  - IDLE -> TRACK when `check_en`=1. No comparison happens during that transition cycle.
  - TRACK -> HALT on a mismatch when `STOP_ON_ERR`=1.
  - TRACK -> IDLE when `check_en`=0.
  - HALT holds until `reset`.
- **Counters:**
  - `cmp_count` increments on every cycle with `cmp` true.
  - `err_count` increments on every mismatch.
  - Both counters saturate, with no wrap.
- **Status outputs:** `error` <= `mm`. `fail` <= `fail` | `mm`.
- **Reset values:** `esperado`=0, `error`=0, `fail`=0, `err_count`=0, `cmp_count`=0, `estado`=IDLE. Reset overrides every other input in the same cycle.
- **Reset mid-operation:** all state returns to the reset values at the next edge. The counter resets to 0 alongside it, so tracking remains aligned.

## Timing
- **Comparison point:** at edge k, `salida` (the counter result of edge k-1) is compared against `esperado` (the model result of edge k-1). There are zero cycles of prediction skew.
- **Error visibility:** `error`, `fail` and the counter updates become visible one cycle after the mismatching sample (edge k+1 outputs).
- **Consecutive mismatches:** these give consecutive `error` pulses. Each one increments `err_count` in TRACK with `STOP_ON_ERR`=0.
- **Simultaneous events:**
  - A mismatch in the same cycle as `check_en` falling is still counted; the FSM then goes to IDLE.
  - `enable` toggling on the mismatch cycle is honoured by the resync formula.
- **Direction changes:** `modo_UpDown` may change every cycle; the model applies the value sampled at each edge.

## Structure
- **Shared package `contador_pkg`:**
  - `WIDTH_DEF`=8.
  - state enum `chk_state_t` {IDLE, TRACK, HALT}.
  - function `contador_next`(v, down), shared with the counter RTL and the testbench.
- **Sub-module `sat_counter`:** parameter CW; ports clk, reset, inc, count. It is instantiated twice, for `err_count` and `cmp_count`.
- **Top level:** the FSM, the model register and the compare logic stay in `contador_checker`.

## Test plan
- **Up count, clean run:** reset, then `check_en`=1, `enable`=1, `modo_UpDown`=0 for 300 cycles with a correct counter -> `err_count`=0, `fail`=0, `cmp_count`=255 (saturated). `esperado` wraps 255->0 with no error.
- **Down count from reset:** reset, then `modo_UpDown`=1, `enable`=1 -> the first compared `salida`=0, then 255, 254, … all match; `error` stays 0.
- **Injected fault with resync (`STOP_ON_ERR`=0):** force `salida`=0x37 for one cycle while expecting 0x10 -> a single `error` pulse, `err_count`=1, `fail`=1. The model resyncs to 0x38 when counting up; the next cycle's 0x38 matches; no further errors.
- **Injected fault with halt (`STOP_ON_ERR`=1):** same fault -> `estado`=HALT, `esperado` frozen; further wrong values do not increment `err_count` (stays 1).
- **Enable and direction toggling:** `enable` alternating 1/0, `modo_UpDown` flipping every 3 cycles over 50 cycles against a correct counter -> zero errors; `esperado` equals `salida` at every compare.
- **Reset mid-run:** assert `reset` for 1 cycle after `err_count`=3 -> all outputs return to their reset values and `estado`=IDLE; the counter resumes from 0 in lockstep.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared definitions for the up/down counter and its checker: widths, checker
// state encoding and the counter's next-value function.
package contador_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HALT  = 2'd2
    } chk_state_t;

    // Next counter value for a w-bit counter (w <= 32); wraps modulo 2^w.
    function automatic logic [31:0] contador_next(input logic [31:0] v,
                                                  input logic        down,
                                                  input int          w = WIDTH_DEF);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        r    = down ? (v - 32'd1) : (v + 32'd1);
        return r & mask;
    endfunction

endpackage

// File: rtl/contador_checker_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/contador_checker.sv
// Cycle-accurate reference model of the up/down counter that compares the
// observed output every checked cycle and reports mismatches.
module contador_checker
    import contador_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int CW          = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             modo_UpDown,
    input  logic [WIDTH-1:0] salida,
    input  logic             check_en,
    output logic [WIDTH-1:0] esperado,
    output logic             error,
    output logic             fail,
    output logic [CW-1:0]    err_count,
    output logic [CW-1:0]    cmp_count,
    output logic [1:0]       estado
);

    chk_state_t       state_q, state_d;
    logic [WIDTH-1:0] esperado_q, esperado_d;
    logic             error_q, error_d;
    logic             fail_q, fail_d;
    logic             cmp;
    logic             mm;
    logic [WIDTH-1:0] next_model;
    logic [WIDTH-1:0] next_obs;

    assign next_model = WIDTH'(contador_next(32'(esperado_q), modo_UpDown, WIDTH));
    assign next_obs   = WIDTH'(contador_next(32'(salida), modo_UpDown, WIDTH));

    // salida at this edge is the counter result of the previous edge, which is
    // exactly what esperado_q holds: no prediction skew.
    assign cmp = (state_q == TRACK) && check_en;
    assign mm  = cmp && (salida != esperado_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (check_en) state_d = TRACK;
            end
            TRACK: begin
                if (mm && STOP_ON_ERR) state_d = HALT;
                else if (!check_en)    state_d = IDLE;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        esperado_d = esperado_q;
        if (state_q != HALT) begin
            if (mm) begin
                // Resync to what the counter actually holds; with halting the
                // model keeps the value that failed.
                if (!STOP_ON_ERR) esperado_d = enable ? next_obs : salida;
            end else if (enable) begin
                esperado_d = next_model;
            end
        end
    end

    assign error_d = mm;
    assign fail_d  = fail_q | mm;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            esperado_q <= '0;
            error_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            esperado_q <= esperado_d;
            error_q    <= error_d;
            fail_q     <= fail_d;
        end
    end

    sat_counter #(.CW(CW)) u_err_count (
        .clk   (clk),
        .reset (reset),
        .inc   (mm),
        .count (err_count)
    );

    sat_counter #(.CW(CW)) u_cmp_count (
        .clk   (clk),
        .reset (reset),
        .inc   (cmp),
        .count (cmp_count)
    );

    assign esperado = esperado_q;
    assign error    = error_q;
    assign fail     = fail_q;
    assign estado   = state_q;

endmodule
